// File: rtl/clk_enable_scheduler_if.sv
// Divide-ratio request channel for clk_enable_scheduler.
// The requester drives valid/value; the scheduler returns ready.
interface clk_enable_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             div_req_valid;
    logic [CNT_W-1:0] div_req_value;
    logic             div_req_ready;

    modport master (
        output div_req_valid,
        output div_req_value,
        input  div_req_ready
    );

    modport slave (
        input  div_req_valid,
        input  div_req_value,
        output div_req_ready
    );
endinterface

// File: rtl/clk_enable_scheduler.sv
// Programmable clock-enable generator for the CPU core with glitch-free
// ratio switching on period boundaries and idle-driven SLEEP gating.
module clk_enable_scheduler #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4,
    parameter int IDLE_LIMIT  = 64
) (
    input  logic                     clk_signal,
    input  logic                     reset,
    clk_enable_scheduler_if.slave    div_req,
    input  logic                     cpu_busy,
    input  logic                     wake,
    output logic                     clk_en,
    output logic [CNT_W-1:0]         cur_div,
    output logic                     sleeping
);

    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT_C = IDLE_W'(IDLE_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_SLEEP  = 2'd2
    } state_t;

    // Ratios of 0 and 1 both mean "enable every cycle"; storing 1 keeps cur_div-1 from underflowing.
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] raw);
        if (raw <= CNT_W'(1)) begin
            eff_div = CNT_W'(1);
        end else begin
            eff_div = raw;
        end
    endfunction

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cur_div_r;
    logic [CNT_W-1:0]    pend_r;
    logic [IDLE_W-1:0]   idle_cnt_r;

    logic                period_end_s;
    logic                accept_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic [IDLE_W-1:0]   idle_next_s;

    // Period decode, handshake acceptance and output decodes of the state registers.
    always_comb begin
        period_end_s = (cnt_r == (cur_div_r - CNT_W'(1)));
        if (period_end_s) begin
            cnt_next_s = CNT_W'(0);
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
        accept_s              = div_req.div_req_valid && (state_r == ST_RUN);
        idle_next_s           = idle_cnt_r + IDLE_W'(1);
        clk_en                = (state_r != ST_SLEEP) && period_end_s;
        div_req.div_req_ready = (state_r == ST_RUN);
        cur_div               = cur_div_r;
        sleeping              = (state_r == ST_SLEEP);
    end

    // Scheduler FSM: period counter, ratio switching and idle/sleep tracking.
    always_ff @(posedge clk_signal) begin
        if (reset) begin
            state_r    <= ST_RUN;
            cnt_r      <= CNT_W'(0);
            idle_cnt_r <= IDLE_W'(0);
            cur_div_r  <= eff_div(CNT_W'(DEFAULT_DIV));
            pend_r     <= eff_div(CNT_W'(DEFAULT_DIV));
        end else begin
            case (state_r)
                ST_RUN: begin
                    cnt_r <= cnt_next_s;
                    if (accept_s) begin
                        pend_r     <= eff_div(div_req.div_req_value);
                        idle_cnt_r <= IDLE_W'(0);
                        state_r    <= ST_SWITCH;
                    end else if (period_end_s) begin
                        if (cpu_busy) begin
                            idle_cnt_r <= IDLE_W'(0);
                        end else if (idle_next_s >= IDLE_LIMIT_C) begin
                            // Entering SLEEP parks the counter so wake-up starts a full period.
                            state_r    <= ST_SLEEP;
                            cnt_r      <= CNT_W'(0);
                            idle_cnt_r <= IDLE_W'(0);
                        end else begin
                            idle_cnt_r <= idle_next_s;
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r;
                    end
                end
                ST_SWITCH: begin
                    // Old period runs to completion; the new ratio starts on a fresh count.
                    if (period_end_s) begin
                        cur_div_r <= pend_r;
                        cnt_r     <= CNT_W'(0);
                        state_r   <= ST_RUN;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                ST_SLEEP: begin
                    cnt_r <= CNT_W'(0);
                    if (wake || cpu_busy) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_SLEEP;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    cnt_r      <= CNT_W'(0);
                    idle_cnt_r <= IDLE_W'(0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Directed bench for clk_enable_scheduler: periods, ratio switching,
// idle sleep/wake, and reset during SWITCH and SLEEP.
module tb_clk_enable_scheduler;

    localparam int CNT_W = 16;

    logic             clk_signal;
    logic             reset;
    logic             cpu_busy;
    logic             wake;
    logic             clk_en;
    logic [CNT_W-1:0] cur_div;
    logic             sleeping;

    int checks_r;
    int errors_r;

    clk_enable_scheduler_if #(.CNT_W(CNT_W)) div_req_bus ();

    clk_enable_scheduler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4),
        .IDLE_LIMIT  (64)
    ) dut (
        .clk_signal (clk_signal),
        .reset      (reset),
        .div_req    (div_req_bus),
        .cpu_busy   (cpu_busy),
        .wake       (wake),
        .clk_en     (clk_en),
        .cur_div    (cur_div),
        .sleeping   (sleeping)
    );

    initial clk_signal = 1'b0;
    always #10 clk_signal = ~clk_signal;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk_signal);
        #1;
    endtask

    task automatic wait_en(input string tag);
        int n;
        n = 0;
        while (!clk_en && n < 200) begin
            step();
            n++;
        end
        check_val(tag, {31'd0, clk_en}, 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        checks_r                  = 0;
        errors_r                  = 0;
        reset                     = 1'b1;
        cpu_busy                  = 1'b1;
        wake                      = 1'b0;
        div_req_bus.div_req_valid = 1'b0;
        div_req_bus.div_req_value = 16'd0;

        // Reset state
        step();
        step();
        check_val("rst_clk_en", {31'd0, clk_en}, 32'd0);
        check_val("rst_cur_div", {16'd0, cur_div}, 32'd4);
        check_val("rst_sleeping", {31'd0, sleeping}, 32'd0);
        check_val("rst_ready", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        reset = 1'b0;

        // 1: default period of 4, pulses at cycles 3, 7, 11
        for (int i = 0; i < 12; i++) begin
            check_val("t1_pulse", {31'd0, clk_en}, ((i % 4) == 3) ? 32'd1 : 32'd0);
            step();
        end

        // 2: request 7 at cnt=1, old period completes, then period 7
        step();
        div_req_bus.div_req_valid = 1'b1;
        div_req_bus.div_req_value = 16'd7;
        check_val("t2_ready_req", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        step();
        div_req_bus.div_req_valid = 1'b0;
        check_val("t2_ready_sw", {31'd0, div_req_bus.div_req_ready}, 32'd0);
        check_val("t2_en_cnt2", {31'd0, clk_en}, 32'd0);
        step();
        check_val("t2_old_pulse", {31'd0, clk_en}, 32'd1);
        check_val("t2_div_old", {16'd0, cur_div}, 32'd4);
        step();
        check_val("t2_div_new", {16'd0, cur_div}, 32'd7);
        check_val("t2_ready_back", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        for (int j = 0; j < 14; j++) begin
            check_val("t2_pulse7", {31'd0, clk_en}, ((j % 7) == 6) ? 32'd1 : 32'd0);
            step();
        end

        // 3: value 0 then value 1 both give a ratio of 1
        div_req_bus.div_req_valid = 1'b1;
        div_req_bus.div_req_value = 16'd0;
        step();
        div_req_bus.div_req_valid = 1'b0;
        wait_en("t3_boundary0");
        step();
        check_val("t3_div0", {16'd0, cur_div}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            check_val("t3_every0", {31'd0, clk_en}, 32'd1);
            step();
        end
        div_req_bus.div_req_valid = 1'b1;
        div_req_bus.div_req_value = 16'd1;
        step();
        div_req_bus.div_req_valid = 1'b0;
        check_val("t3_ready_sw1", {31'd0, div_req_bus.div_req_ready}, 32'd0);
        check_val("t3_en_sw1", {31'd0, clk_en}, 32'd1);
        step();
        check_val("t3_div1", {16'd0, cur_div}, 32'd1);
        check_val("t3_every1", {31'd0, clk_en}, 32'd1);
        div_req_bus.div_req_valid = 1'b1;
        div_req_bus.div_req_value = 16'd4;
        step();
        div_req_bus.div_req_valid = 1'b0;
        step();
        check_val("t3_div_back4", {16'd0, cur_div}, 32'd4);

        // 4: 64 idle pulses of 4 cycles -> SLEEP at cycle 256
        cpu_busy = 1'b0;
        n        = 0;
        pulses   = 0;
        while (!sleeping && n < 400) begin
            if (clk_en) pulses++;
            step();
            n++;
        end
        check_val("t4_sleep_cycle", n, 32'd256);
        check_val("t4_idle_pulses", pulses, 32'd64);
        check_val("t4_sleeping", {31'd0, sleeping}, 32'd1);
        repeat (5) step();
        check_val("t4_en_sleep", {31'd0, clk_en}, 32'd0);
        check_val("t4_ready_sleep", {31'd0, div_req_bus.div_req_ready}, 32'd0);
        wake = 1'b1;
        step();
        wake = 1'b0;
        check_val("t4_woke", {31'd0, sleeping}, 32'd0);
        check_val("t4_ready_woke", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        for (int j = 0; j < 4; j++) begin
            check_val("t4_first_pulse", {31'd0, clk_en}, (j == 3) ? 32'd1 : 32'd0);
            step();
        end

        // 5: request accept on the 64th idle pulse wins over SLEEP
        cpu_busy = 1'b1;
        wait_en("t5_busy_pulse");
        step();
        cpu_busy = 1'b0;
        repeat (252) step();
        repeat (3) step();
        div_req_bus.div_req_valid = 1'b1;
        div_req_bus.div_req_value = 16'd5;
        check_val("t5_en_64th", {31'd0, clk_en}, 32'd1);
        check_val("t5_ready_64th", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        step();
        div_req_bus.div_req_valid = 1'b0;
        check_val("t5_not_sleep", {31'd0, sleeping}, 32'd0);
        check_val("t5_switch", {31'd0, div_req_bus.div_req_ready}, 32'd0);
        repeat (3) step();
        check_val("t5_boundary", {31'd0, clk_en}, 32'd1);
        check_val("t5_div_old", {16'd0, cur_div}, 32'd4);
        step();
        check_val("t5_div_new", {16'd0, cur_div}, 32'd5);
        for (int j = 0; j < 5; j++) begin
            check_val("t5_pulse5", {31'd0, clk_en}, (j == 4) ? 32'd1 : 32'd0);
            step();
        end
        n = 0;
        while (!sleeping && n < 500) begin
            step();
            n++;
        end
        check_val("t5_idle_cleared", n, 32'd315);

        // 6: reset during SLEEP, then during SWITCH with pend=9
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("t6_sl_sleeping", {31'd0, sleeping}, 32'd0);
        check_val("t6_sl_div", {16'd0, cur_div}, 32'd4);
        check_val("t6_sl_ready", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        cpu_busy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_val("t6_sl_pulse", {31'd0, clk_en}, (j == 3) ? 32'd1 : 32'd0);
            step();
        end
        div_req_bus.div_req_valid = 1'b1;
        div_req_bus.div_req_value = 16'd9;
        step();
        div_req_bus.div_req_valid = 1'b0;
        check_val("t6_sw_ready", {31'd0, div_req_bus.div_req_ready}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("t6_sw_div", {16'd0, cur_div}, 32'd4);
        check_val("t6_sw_ready_back", {31'd0, div_req_bus.div_req_ready}, 32'd1);
        for (int j = 0; j < 8; j++) begin
            check_val("t6_sw_pulse", {31'd0, clk_en}, ((j % 4) == 3) ? 32'd1 : 32'd0);
            step();
        end
        check_val("t6_pend_discarded", {16'd0, cur_div}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
